// File: rtl/mcu_bus_ctrl_pkg.sv
// rtl/mcu_bus_ctrl_pkg.sv - shared FSM encoding, address field bounds and error read value
package mcu_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_DRIVE   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // MCU address split: slot index on top, register offset below
    localparam int SLOT_MSB = 13;
    localparam int SLOT_LSB = 11;
    localparam int OFF_MSB  = 10;
    localparam int OFF_LSB  = 0;

    // Value returned to the MCU on timeout or unmapped slot
    localparam logic [7:0] ERR_RDATA = 8'h00;

endpackage

// File: rtl/mcu_bus_ctrl_sync2.sv
// rtl/mcu_bus_ctrl_sync2.sv - two-flop single-bit synchronizer
// Ports: clk, reset (async active-low), d (asynchronous input), q (synchronized output).
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mcu_bus_ctrl.sv
// rtl/mcu_bus_ctrl.sv - async MCU parallel bus to synchronous peripheral slot bridge
// Ports: clk, reset (async active-low); MCU side ncs/nwe/nrd/address/data_bus (inout);
// peripheral side perip_sel/perip_addr/perip_wdata/perip_we/perip_re out,
// perip_rdata/perip_ack in; bus_err one-cycle error pulse.
module mcu_bus_ctrl
    import mcu_bus_ctrl_pkg::*;
#(
    parameter int CLK_FREQ    = 96000000,
    parameter int NUM_PERIP   = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ncs,
    input  logic                   nwe,
    input  logic                   nrd,
    input  logic [13:0]            address,
    inout  wire  [7:0]             data_bus,
    output logic [NUM_PERIP-1:0]   perip_sel,
    output logic [10:0]            perip_addr,
    output logic [7:0]             perip_wdata,
    output logic                   perip_we,
    output logic                   perip_re,
    input  logic [8*NUM_PERIP-1:0] perip_rdata,
    input  logic [NUM_PERIP-1:0]   perip_ack,
    output logic                   bus_err
);

    if (CLK_FREQ <= 0 || NUM_PERIP < 1 || NUM_PERIP > 8 ||
        ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_param_check
        $error("mcu_bus_ctrl: parameter out of range");
    end

    logic ncs_s, nwe_s, nrd_s;

    sync2 #(.RESET_VAL(1'b1)) u_sync_ncs (.clk(clk), .reset(reset), .d(ncs), .q(ncs_s));
    sync2 #(.RESET_VAL(1'b1)) u_sync_nwe (.clk(clk), .reset(reset), .d(nwe), .q(nwe_s));
    sync2 #(.RESET_VAL(1'b1)) u_sync_nrd (.clk(clk), .reset(reset), .d(nrd), .q(nrd_s));

    state_t         state, state_nxt;
    logic [2:0]     slot_q;
    logic           is_read_q;
    logic           abort_q;     // ncs went high mid-access: finish internally, never drive
    logic [7:0]     rd_reg;
    logic [7:0]     cnt;         // cycles spent in ACCESS; 0 marks the strobe cycle
    logic [7:0]     rd_slice;
    logic           ack_slot;
    logic           mapped;
    logic           timed_out;
    logic           access_done;
    logic           access_err;
    logic           strobe;
    logic           drive;
    logic [NUM_PERIP-1:0] sel_onehot;

    // Mux the addressed slot's data and ack without indexing past NUM_PERIP
    always_comb begin
        rd_slice = '0;
        ack_slot = 1'b0;
        for (int i = 0; i < NUM_PERIP; i++) begin
            if (slot_q == 3'(i)) begin
                rd_slice = perip_rdata[8*i +: 8];
                ack_slot = perip_ack[i];
            end
        end
    end

    assign mapped      = (32'(slot_q) < 32'(NUM_PERIP));
    assign sel_onehot  = NUM_PERIP'(1) << slot_q;
    assign timed_out   = (cnt == 8'(ACK_TIMEOUT));
    // Ack wins over a timeout landing on the same cycle
    assign access_done = !mapped || ack_slot || timed_out;
    assign access_err  = !mapped || (!ack_slot && timed_out);
    assign strobe      = (state == ST_ACCESS) && (cnt == 8'd0) && mapped;

    assign perip_sel = ((state == ST_ACCESS) && mapped) ? sel_onehot : '0;
    assign perip_we  = strobe && !is_read_q;
    assign perip_re  = strobe && is_read_q;

    // Combinational from state so reset releases the bus without waiting for a clock
    assign drive    = (state == ST_DRIVE) && !ncs_s && !nrd_s;
    assign data_bus = drive ? rd_reg : 8'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!ncs_s) begin
                    if (!nwe_s && !nrd_s) begin
                        bus_err   = 1'b1;
                        state_nxt = ST_RELEASE;
                    end else if (nwe_s != nrd_s) begin
                        state_nxt = ST_LATCH;
                    end
                end
            end
            ST_LATCH:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (access_done) begin
                    bus_err   = access_err;
                    state_nxt = (is_read_q && !abort_q && !ncs_s) ? ST_DRIVE : ST_RELEASE;
                end
            end
            ST_DRIVE: begin
                if (nrd_s || ncs_s) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (ncs_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perip_addr  <= '0;
            perip_wdata <= '0;
            slot_q      <= '0;
            is_read_q   <= 1'b0;
            abort_q     <= 1'b0;
            rd_reg      <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    abort_q <= 1'b0;
                    cnt     <= '0;
                end
                ST_LATCH: begin
                    perip_addr <= address[OFF_MSB:OFF_LSB];
                    slot_q     <= address[SLOT_MSB:SLOT_LSB];
                    is_read_q  <= !nrd_s;
                    if (!nwe_s) begin
                        perip_wdata <= data_bus;
                    end
                    abort_q <= ncs_s;
                    cnt     <= '0;
                end
                ST_ACCESS: begin
                    abort_q <= abort_q | ncs_s;
                    if (access_done) begin
                        cnt <= '0;
                        if (access_err) begin
                            rd_reg <= ERR_RDATA;
                        end else if (is_read_q) begin
                            rd_reg <= rd_slice;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_bus_ctrl.sv
// tb/tb_mcu_bus_ctrl.sv - directed self-checking bench for mcu_bus_ctrl
module tb_mcu_bus_ctrl;
    import mcu_bus_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ncs, nwe, nrd;
    logic [13:0] address;
    wire  [7:0]  data_bus;
    wire  [7:0]  data_bus4;
    logic [7:0]  tb_drv;
    logic        tb_oe;

    logic [7:0]  perip_sel;
    logic [10:0] perip_addr;
    logic [7:0]  perip_wdata;
    logic        perip_we, perip_re, bus_err;
    logic [63:0] perip_rdata;
    logic [7:0]  perip_ack;

    logic [3:0]  sel4;
    logic [10:0] addr4;
    logic [7:0]  wdata4;
    logic        we4, re4, bus_err4;
    logic [31:0] rdata4;
    logic [3:0]  ack4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign data_bus = tb_oe ? tb_drv : 8'bz;

    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup (data_bus[g]);
        pullup (data_bus4[g]);
    end

    mcu_bus_ctrl dut (
        .clk(clk), .reset(reset), .ncs(ncs), .nwe(nwe), .nrd(nrd),
        .address(address), .data_bus(data_bus),
        .perip_sel(perip_sel), .perip_addr(perip_addr), .perip_wdata(perip_wdata),
        .perip_we(perip_we), .perip_re(perip_re),
        .perip_rdata(perip_rdata), .perip_ack(perip_ack), .bus_err(bus_err)
    );

    mcu_bus_ctrl #(.NUM_PERIP(4)) dut4 (
        .clk(clk), .reset(reset), .ncs(ncs), .nwe(nwe), .nrd(nrd),
        .address(address), .data_bus(data_bus4),
        .perip_sel(sel4), .perip_addr(addr4), .perip_wdata(wdata4),
        .perip_we(we4), .perip_re(re4),
        .perip_rdata(rdata4), .perip_ack(ack4), .bus_err(bus_err4)
    );

    task automatic test_reset();
        reset = 1'b0; ncs = 1'b1; nwe = 1'b1; nrd = 1'b1;
        address = '0; tb_drv = '0; tb_oe = 1'b0;
        perip_rdata = '0; perip_ack = '0; rdata4 = '0; ack4 = 4'hF;
        @(negedge clk);
        n_checks++; if (perip_sel !== 8'h00) begin n_fail++; $display("FAIL reset_sel got %h exp 00", perip_sel); end
        n_checks++; if (perip_we !== 1'b0 || perip_re !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got we=%b re=%b exp 0 0", perip_we, perip_re); end
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b exp 0", bus_err); end
        n_checks++; if (perip_addr !== 11'h000 || perip_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_addr_wdata got %h %h exp 000 00", perip_addr, perip_wdata); end
        n_checks++; if (addr4 !== 11'h000 || wdata4 !== 8'h00) begin n_fail++; $display("FAIL reset_addr_wdata4 got %h %h exp 000 00", addr4, wdata4); end
        n_checks++; if (data_bus !== 8'hFF) begin n_fail++; $display("FAIL reset_data_bus_z got %h exp FF(pulled)", data_bus); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        int we_cnt = 0, re_cnt = 0, err_cnt = 0, sc = -10;
        logic seen = 1'b0;
        logic [7:0] sel_at = '0, wdata_at = '0;
        logic [10:0] addr_at = '0;
        address = 14'h0805; tb_drv = 8'hA5; tb_oe = 1'b1; ncs = 1'b0; nwe = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (perip_we) begin we_cnt++; seen = 1'b1; sc = c; sel_at = perip_sel; addr_at = perip_addr; wdata_at = perip_wdata; end
            if (perip_re) re_cnt++;
            if (bus_err) err_cnt++;
            if (c == sc + 1) begin
                n_checks++; if (perip_sel !== 8'h02 || perip_we !== 1'b0) begin n_fail++; $display("FAIL write_sel_held got sel=%h we=%b exp 02 0", perip_sel, perip_we); end
            end
            perip_ack[1] = seen && (c == sc + 1);
            if (c == 10) begin ncs = 1'b1; nwe = 1'b1; tb_oe = 1'b0; end
        end
        perip_ack = '0;
        n_checks++; if (we_cnt != 1) begin n_fail++; $display("FAIL write_we_pulses got %0d exp 1", we_cnt); end
        n_checks++; if (re_cnt != 0) begin n_fail++; $display("FAIL write_re_pulses got %0d exp 0", re_cnt); end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL write_bus_err got %0d exp 0", err_cnt); end
        n_checks++; if (sel_at !== 8'h02) begin n_fail++; $display("FAIL write_sel got %h exp 02", sel_at); end
        n_checks++; if (addr_at !== 11'h005) begin n_fail++; $display("FAIL write_addr got %h exp 005", addr_at); end
        n_checks++; if (wdata_at !== 8'hA5) begin n_fail++; $display("FAIL write_wdata got %h exp A5", wdata_at); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_read();
        int we_cnt = 0, re_cnt = 0, err_cnt = 0;
        logic [7:0] sel_at = '0;
        logic [10:0] addr_at = '0;
        perip_rdata = '0; perip_rdata[55:48] = 8'h5C; perip_ack = 8'h40;
        address = 14'h3003; ncs = 1'b0; nrd = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (perip_re) begin re_cnt++; sel_at = perip_sel; addr_at = perip_addr; end
            if (perip_we) we_cnt++;
            if (bus_err) err_cnt++;
            if (c == 3) begin n_checks++; if (data_bus !== 8'hFF) begin n_fail++; $display("FAIL read_not_early got %h exp FF(pulled)", data_bus); end end
            if (c == 4) begin n_checks++; if (data_bus !== 8'h5C) begin n_fail++; $display("FAIL read_latency5 got %h exp 5C", data_bus); end end
            if (c == 7) begin n_checks++; if (data_bus !== 8'h5C) begin n_fail++; $display("FAIL read_held got %h exp 5C", data_bus); end end
            if (c == 8) nrd = 1'b1;
            if (c == 11) begin n_checks++; if (data_bus !== 8'hFF) begin n_fail++; $display("FAIL read_release got %h exp FF(pulled)", data_bus); end end
            if (c == 12) ncs = 1'b1;
        end
        perip_ack = '0;
        n_checks++; if (re_cnt != 1) begin n_fail++; $display("FAIL read_re_pulses got %0d exp 1", re_cnt); end
        n_checks++; if (we_cnt != 0 || err_cnt != 0) begin n_fail++; $display("FAIL read_no_we_err got we=%0d err=%0d exp 0 0", we_cnt, err_cnt); end
        n_checks++; if (sel_at !== 8'h40 || addr_at !== 11'h003) begin n_fail++; $display("FAIL read_sel_addr got %h %h exp 40 003", sel_at, addr_at); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_timeout();
        int re_cnt = 0, err_cnt = 0, re_c = -100, err_c = -100;
        perip_ack = '0; perip_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        address = 14'h1010; ncs = 1'b0; nrd = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (perip_re) begin re_cnt++; re_c = c; end
            if (bus_err) begin err_cnt++; err_c = c; end
            if (c == err_c + 1) begin n_checks++; if (data_bus !== 8'h00) begin n_fail++; $display("FAIL timeout_rdata got %h exp 00", data_bus); end end
            if (c == 30) nrd = 1'b1;
            if (c == 33) ncs = 1'b1;
        end
        n_checks++; if (re_cnt != 1) begin n_fail++; $display("FAIL timeout_re_pulses got %0d exp 1", re_cnt); end
        n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL timeout_err_pulses got %0d exp 1", err_cnt); end
        n_checks++; if (err_c - re_c != 15) begin n_fail++; $display("FAIL timeout_delay got %0d exp 15", err_c - re_c); end
        perip_rdata = '0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_unmapped();
        int strobes = 0, err_cnt = 0, sel_nz = 0;
        address = 14'h2000; ncs = 1'b0; nrd = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (we4 || re4) strobes++;
            if (bus_err4) err_cnt++;
            if (sel4 !== 4'h0) sel_nz++;
            if (c == 4) begin n_checks++; if (data_bus4 !== 8'h00) begin n_fail++; $display("FAIL unmapped_rdata got %h exp 00", data_bus4); end end
            if (c == 8) nrd = 1'b1;
            if (c == 10) ncs = 1'b1;
        end
        n_checks++; if (strobes != 0 || sel_nz != 0) begin n_fail++; $display("FAIL unmapped_no_strobe got strobes=%0d sel=%0d exp 0 0", strobes, sel_nz); end
        n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL unmapped_err_pulses got %0d exp 1", err_cnt); end
        repeat (25) @(negedge clk);
    endtask

    task automatic test_both_low();
        int strobes = 0, err_cnt = 0;
        address = 14'h0805; ncs = 1'b0; nwe = 1'b0; nrd = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (perip_we || perip_re) strobes++;
            if (bus_err) err_cnt++;
            if (c == 6) begin ncs = 1'b1; nwe = 1'b1; nrd = 1'b1; end
        end
        n_checks++; if (strobes != 0) begin n_fail++; $display("FAIL both_low_strobes got %0d exp 0", strobes); end
        n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL both_low_err_pulses got %0d exp 1", err_cnt); end
        n_checks++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL both_low_idle got %0d exp %0d", dut.state, ST_IDLE); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_drive();
        int strobes = 0;
        logic found = 1'b0;
        perip_rdata = '0; perip_rdata[55:48] = 8'h5C; perip_ack = 8'h40;
        address = 14'h3003; ncs = 1'b0; nrd = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (data_bus === 8'h5C) begin found = 1'b1; break; end
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rst_drive_reached got %b exp 1", found); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (data_bus !== 8'hFF) begin n_fail++; $display("FAIL rst_drive_bus_z got %h exp FF(pulled)", data_bus); end
        n_checks++; if (perip_sel !== 8'h00 || perip_we !== 1'b0 || perip_re !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_drive_outputs got sel=%h we=%b re=%b err=%b exp 00 0 0 0", perip_sel, perip_we, perip_re, bus_err); end
        n_checks++; if (perip_addr !== 11'h000 || perip_wdata !== 8'h00 || dut.rd_reg !== 8'h00) begin n_fail++; $display("FAIL rst_drive_regs got %h %h %h exp 000 00 00", perip_addr, perip_wdata, dut.rd_reg); end
        ncs = 1'b1; nrd = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (perip_we || perip_re) strobes++;
        end
        n_checks++; if (strobes != 0) begin n_fail++; $display("FAIL rst_drive_no_strobe got %0d exp 0", strobes); end
        perip_ack = '0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_unmapped();
        test_both_low();
        test_reset_drive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
